// File: rtl/jtcontra_gfx_linereader.sv
// Display-side line buffer reader for the Contra tilemap.
// Owns the two-bank 1024x9 line RAM: the renderer writes one bank while this
// block scans the other in step with pxl_cen, erasing each location after use.
module jtcontra_gfx_linereader #(
  parameter logic [8:0] DUMP_START = 9'd0,
  parameter bit         CLR_EN     = 1'b1,
  parameter logic [8:0] CLR_VAL    = 9'd0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pxl_cen,
  input  logic       LHBL,
  input  logic       LVBL,
  input  logic       line,
  input  logic       scr_we,
  input  logic [8:0] line_din,
  input  logic [9:0] line_addr,
  output logic [8:0] pxl,
  output logic       pxl_opaque,
  output logic [8:0] rd_addr
);

  localparam int unsigned XW    = 9;
  localparam int unsigned AW    = XW + 1;
  localparam int unsigned DW    = 9;
  localparam int unsigned DEPTH = 1 << AW;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SCAN = 1'b1;

  // Line buffer storage and its registered read data (not reset)
  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] dout_q;

  // Scan control
  logic [0:0]    state_q, state_d;
  logic [XW-1:0] cnt_q, cnt_d;
  logic          last_lhbl_q;
  logic          rd_go_c;

  // Read pipeline: stage 1 holds the presented address, stage 2 the RAM data
  logic          s1_vld_q;
  logic [AW-1:0] s1_addr_q;
  logic          s2_vld_q;

  logic vis_c;
  logic lhbl_rise_c;
  logic s1_live_c;
  logic clr_we_c;

  assign vis_c       = LHBL & LVBL;
  assign lhbl_rise_c = LHBL & ~last_lhbl_q;
  // A read in flight is dropped if blanking starts before its data stage
  assign s1_live_c   = s1_vld_q & vis_c;
  // Renderer owns the address on a same-cycle collision
  assign clr_we_c    = CLR_EN && s1_live_c && !(scr_we && (line_addr == s1_addr_q));

  // Scan state and read counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      last_lhbl_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_lhbl_q <= LHBL;
    end
  end

  // Scan next-state: arm on LHBL rise in active field, read on each pxl_cen
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rd_go_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (lhbl_rise_c && LVBL) begin
          state_d = ST_SCAN;
          cnt_d   = DUMP_START;
        end
      end
      ST_SCAN: begin
        if (!vis_c) begin
          state_d = ST_IDLE;
        end else if (pxl_cen) begin
          rd_go_c = 1'b1;
          cnt_d   = cnt_q + XW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Address stage: latch the bank not being rendered plus the scan x
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld_q  <= 1'b0;
      s1_addr_q <= '0;
      rd_addr   <= '0;
    end else begin
      s1_vld_q <= rd_go_c;
      if (rd_go_c) begin
        s1_addr_q <= {~line, cnt_q};
        rd_addr   <= cnt_q;
      end
    end
  end

  // Dual-port RAM: renderer write, read-then-erase on the scan port
  always_ff @(posedge clk) begin
    if (clr_we_c) begin
      mem_q[s1_addr_q] <= CLR_VAL;
    end
    if (scr_we) begin
      mem_q[line_addr] <= line_din;
    end
    if (s1_live_c) begin
      dout_q <= mem_q[s1_addr_q];
    end
  end

  // Data-valid tracking for the output stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_vld_q <= 1'b0;
    end else begin
      s2_vld_q <= s1_live_c;
    end
  end

  // Output stage: blank forces transparent, otherwise hold until new data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pxl        <= '0;
      pxl_opaque <= 1'b0;
    end else if (!vis_c) begin
      pxl        <= '0;
      pxl_opaque <= 1'b0;
    end else if (s2_vld_q) begin
      pxl        <= dout_q;
      pxl_opaque <= (dout_q[3:0] != 4'd0);
    end
  end

endmodule

// File: tb/tb_jtcontra_gfx_linereader.sv
// Bench for the line buffer reader: three instances (default, no erase,
// start offset 16) share stimulus; each has its own memory image model.
module tb_jtcontra_gfx_linereader;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pxl_cen = 1'b0;
  logic       LHBL = 1'b0;
  logic       LVBL = 1'b1;
  logic       line = 1'b0;
  logic       scr_we = 1'b0;
  logic [8:0] line_din = '0;
  logic [9:0] line_addr = '0;

  logic [8:0] pxl_o [3];
  logic       opq_o [3];
  logic [8:0] rda_o [3];

  jtcontra_gfx_linereader u_dut0 (
    .clk(clk), .rst_n(rst_n), .pxl_cen(pxl_cen), .LHBL(LHBL), .LVBL(LVBL),
    .line(line), .scr_we(scr_we), .line_din(line_din), .line_addr(line_addr),
    .pxl(pxl_o[0]), .pxl_opaque(opq_o[0]), .rd_addr(rda_o[0])
  );

  jtcontra_gfx_linereader #(.CLR_EN(1'b0)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .pxl_cen(pxl_cen), .LHBL(LHBL), .LVBL(LVBL),
    .line(line), .scr_we(scr_we), .line_din(line_din), .line_addr(line_addr),
    .pxl(pxl_o[1]), .pxl_opaque(opq_o[1]), .rd_addr(rda_o[1])
  );

  jtcontra_gfx_linereader #(.DUMP_START(9'd16)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .pxl_cen(pxl_cen), .LHBL(LHBL), .LVBL(LVBL),
    .line(line), .scr_we(scr_we), .line_din(line_din), .line_addr(line_addr),
    .pxl(pxl_o[2]), .pxl_opaque(opq_o[2]), .rd_addr(rda_o[2])
  );

  always #5 clk = ~clk;

  // Reference: per-instance memory image, scan start and erase behaviour
  logic [8:0]  mdl [3][1024];
  int unsigned start_x [3];
  bit          clr [3];
  logic [8:0]  exp_pxl [3];
  int          rd_n;
  int          n_chk = 0;
  int          n_pass = 0;
  int          n_fail = 0;

  task automatic check(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    n_chk++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("%s_pxl%0d", tag, k), pxl_o[k], exp_pxl[k]);
      check($sformatf("%s_opq%0d", tag, k), {8'd0, opq_o[k]},
            {8'd0, (exp_pxl[k][3:0] != 4'd0)});
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  // Renderer write, one clk
  task automatic wr(input logic [9:0] a, input logic [8:0] d);
    scr_we = 1'b1; line_addr = a; line_din = d;
    @(posedge clk); #1;
    scr_we = 1'b0;
    for (int k = 0; k < 3; k++) mdl[k][a] = d;
  endtask

  // One pixel read; optionally the renderer hits the erased address at T+1
  task automatic cen_read(input bit coll, input logic [8:0] coll_d);
    logic [9:0]  a [3];
    logic [8:0]  nv [3];
    int unsigned x;
    for (int k = 0; k < 3; k++) begin
      x = (start_x[k] + rd_n) % 512;
      a[k] = {~line, 9'(x)};
      nv[k] = mdl[k][a[k]];
      if (clr[k]) mdl[k][a[k]] = 9'd0;
    end
    pxl_cen = 1'b1;
    @(posedge clk); #1;
    pxl_cen = 1'b0;
    if (coll) begin
      scr_we = 1'b1; line_addr = a[0]; line_din = coll_d;
    end
    for (int k = 0; k < 3; k++) check($sformatf("rd_addr%0d", k), rda_o[k], a[k][8:0]);
    @(posedge clk); #1;
    if (coll) begin
      scr_we = 1'b0;
      for (int k = 0; k < 3; k++) mdl[k][a[0]] = coll_d;
    end
    check_all("hold");
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) exp_pxl[k] = nv[k];
    check_all("pxl");
    rd_n++;
  endtask

  task automatic line_start(input bit ln);
    line = ln; LHBL = 1'b1; rd_n = 0;
    @(posedge clk); #1;
    idle($urandom_range(0, 2));
  endtask

  task automatic line_end();
    LHBL = 1'b0;
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) exp_pxl[k] = '0;
    check_all("hblank");
    idle(3);
  endtask

  task automatic run_line(input int ncen, input bit ln);
    line_start(ln);
    for (int i = 0; i < ncen; i++) begin
      cen_read(1'b0, 9'd0);
      idle($urandom_range(0, 1));
    end
    line_end();
  endtask

  initial begin
    start_x = '{0, 0, 16};
    clr     = '{1'b1, 1'b0, 1'b1};
    for (int k = 0; k < 3; k++) exp_pxl[k] = '0;

    // Reset state
    #23;
    check_all("reset");
    for (int k = 0; k < 3; k++) check($sformatf("reset_rda%0d", k), rda_o[k], 9'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(2);

    // Bank 0 holds x, bank 1 random
    for (int x = 0; x < 512; x++) wr({1'b0, 9'(x)}, 9'(x));
    for (int x = 0; x < 512; x++) wr({1'b1, 9'(x)}, 9'($urandom));

    // Basic read of bank 0, then bank 1, then re-read bank 0 (erased or not)
    run_line(320, 1'b1);
    run_line(40, 1'b0);
    run_line(40, 1'b1);

    // Long line: offset instance wraps 511 -> 0
    run_line(500, 1'b0);

    // Vertical blank mid-line: output drops, no further reads or erases
    for (int x = 0; x < 64; x++) wr({1'b0, 9'(x)}, 9'($urandom_range(1, 511)));
    line_start(1'b1);
    for (int i = 0; i < 10; i++) cen_read(1'b0, 9'd0);
    idle(2);
    LVBL = 1'b0;
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) exp_pxl[k] = '0;
    check_all("vblank");
    pxl_cen = 1'b1;
    @(posedge clk); #1;
    pxl_cen = 1'b0;
    idle(3);
    check_all("vblank_hold");
    LVBL = 1'b1;
    for (int i = 0; i < 3; i++) begin
      pxl_cen = 1'b1;
      @(posedge clk); #1;
      pxl_cen = 1'b0;
      idle(3);
    end
    check_all("no_rearm");
    line_end();
    run_line(64, 1'b1);

    // Renderer write collides with the erase of the same address
    line_start(1'b1);
    for (int i = 0; i < 3; i++) cen_read(1'b0, 9'd0);
    cen_read(1'b1, 9'h0F3);
    cen_read(1'b0, 9'd0);
    line_end();
    check("coll_model", mdl[0][10'd3], 9'h0F3);
    run_line(8, 1'b1);

    // Asynchronous reset mid-line
    for (int x = 0; x < 32; x++) wr({1'b0, 9'(x)}, 9'h1A5);
    line_start(1'b1);
    for (int i = 0; i < 5; i++) cen_read(1'b0, 9'd0);
    check("pre_rst_pxl0", pxl_o[0], 9'h1A5);
    idle(2);
    #3 rst_n = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) exp_pxl[k] = '0;
    check_all("async_rst");
    for (int k = 0; k < 3; k++) check($sformatf("rst_rda%0d", k), rda_o[k], 9'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      pxl_cen = 1'b1;
      @(posedge clk); #1;
      pxl_cen = 1'b0;
      idle(3);
      check_all("post_rst");
      for (int k = 0; k < 3; k++) check($sformatf("post_rst_rda%0d", k), rda_o[k], 9'd0);
    end
    line_end();
    run_line(16, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/jtcontra_gfx_linereader.md
Name: jtcontra_gfx_linereader

Overview:
- Display-side end of the tilemap line-buffer interface.
- Owns the two-bank 1024x9 line buffer RAM. The write port is driven by the tilemap renderer (scr_we / line_din / line_addr / line).
- The read port scans the bank rendered during the previous line, in step with the pixel clock enable. It outputs the 9-bit pixel {scrwin, pal[3:0], colour[3:0]} to the colour mixer.
- Each location is erased after it is read, so the renderer always starts from a transparent bank.

Parameters:
- DUMP_START, 9'd0, value loaded into the read counter at the start of each active line.
- CLR_EN, 1, 1 = erase each location to CLR_VAL after reading it; 0 = buffer is never cleared.
- CLR_VAL, 9'd0, value written on erase (colour 0 = transparent).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- pxl_cen  in  1  pixel clock enable, one clk wide, at most every 2nd clk.
- LHBL  in  1  horizontal blank, active-low (high = active video).
- LVBL  in  1  vertical blank, active-low.
- line  in  1  bank being written by the renderer; reader uses ~line.
- scr_we  in  1  renderer write strobe.
- line_din  in  9  renderer write data.
- line_addr  in  10  renderer write address {bank, x[8:0]}.
- pxl  out  9  {scrwin, pal[3:0], colour[3:0]}.
- pxl_opaque  out  1  colour nibble != 0.
- rd_addr  out  9  current read x (debug/verification).

Behaviour:
- Reset (rst_n low, asynchronous): pxl = 0, pxl_opaque = 0, rd_addr = 0, read counter = 0, clear pipeline idle. RAM contents are not reset. Asserting rst_n mid-line aborts the line immediately; reading resumes at the next LHBL rising edge.
- The reader registers LHBL internally (last_LHBL). On LHBL rising edge with LVBL high, the read counter is loaded with DUMP_START. The rising edge does not need a pxl_cen.
- Active read: while LHBL and LVBL are high, each pxl_cen reads RAM[{~line, cnt}] and increments cnt by 1. cnt is 9 bits and wraps 511->0; no saturation.
- Latency: address is presented on the edge where pxl_cen is sampled high (edge T). RAM data is registered at T+1. pxl and pxl_opaque update at T+2 and hold until the next update.
- Blanking: whenever LHBL or LVBL is low, pxl and pxl_opaque are forced to 0 on the next clk edge. No reads or clears happen during blanking.
- Erase: with CLR_EN=1, at T+1 the read port writes CLR_VAL to the address read at T. This is why pxl_cen must be spaced at least 2 clk apart.
- Port arbitration: the write port (renderer) and the read/clear port are independent true dual-port. If both write the same address on the same clk, the renderer write wins. This only occurs if line toggles mid-line.
- Bank swap: line is sampled on every read. Its toggle at LHBL rise therefore takes effect from the first read of the new line.
- Flip and scroll are handled by the renderer. The reader always scans addresses upward.

Test Plan:
- Reset: drop rst_n mid-line with pxl = 9'h1A5 -> pxl = 0 and rd_addr = 0 asynchronously. After rst_n rises, no pxl change occurs until the next LHBL rising edge.
- Basic read: renderer writes bank 0, x = 0..319, data = x[8:0]. Set line = 1, LHBL rises, pxl_cen every 4 clk. -> pxl sequence 0,1,2,…, each appearing 2 clk after its cen; pxl_opaque = 0 only when x[3:0] = 0.
- Erase: after the line above, switch back (line = 0 read bank 1 vs bank 0). Re-read bank 0 without rewriting -> all pxl = 0. Repeat with CLR_EN = 0 -> original data returned.
- DUMP_START = 9'd16: first pxl of the line = content of address 16; rd_addr wraps 511 -> 0 when cen count exceeds 496.
- Blanking: drop LVBL during active reads -> pxl = 0 one clk later; no RAM writes occur (bank contents intact).
- Collision: renderer writes 9'h0F3 to the address being cleared in the same clk -> RAM holds 9'h0F3 afterwards.
